pb_port_master: RTL and testbench

PB_PORT_MASTER -- requirements
Module: pb_port_master

---
 rtl/pb_port_master.sv | 131 +++++++++++++
 tb/tb_pb_port_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_port_master.sv
// Peripheral-bus port master: turns cmd/rsp handshakes into port_id/strobe bus cycles
// and latches a peripheral interrupt independently of the bus sequencer.
module pb_port_master #(
    parameter int IRQ_EDGE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_port,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    input  logic [7:0] in_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic       interrupt,
    output logic       irq_pending,
    input  logic       irq_clear
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       wr_q;
    logic       wr_nxt;
    logic [7:0] port_id_nxt;
    logic [7:0] out_port_nxt;
    logic [7:0] rsp_data_nxt;
    logic       rsp_valid_nxt;
    logic       write_strobe_nxt;
    logic       read_strobe_nxt;
    logic       irq_hist;
    logic       irq_set;

    // Only combinational output; forced low while reset is asserted.
    assign cmd_ready = (state == IDLE) && reset;

    always_comb begin
        state_nxt        = state;
        wr_nxt           = wr_q;
        port_id_nxt      = port_id;
        out_port_nxt     = out_port;
        rsp_data_nxt     = rsp_data;
        rsp_valid_nxt    = rsp_valid;
        write_strobe_nxt = 1'b0;
        read_strobe_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    wr_nxt       = cmd_write;
                    port_id_nxt  = cmd_port;
                    out_port_nxt = cmd_data;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                write_strobe_nxt = wr_q;
                read_strobe_nxt  = ~wr_q;
                state_nxt        = STROBE;
            end
            STROBE: begin
                // Peripherals have had one cycle since port_id changed, so in_port is valid now.
                if (wr_q) begin
                    state_nxt = IDLE;
                end else begin
                    rsp_data_nxt  = in_port;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            wr_q         <= 1'b0;
            port_id      <= 8'h00;
            out_port     <= 8'h00;
            rsp_data     <= 8'h00;
            rsp_valid    <= 1'b0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_q         <= wr_nxt;
            port_id      <= port_id_nxt;
            out_port     <= out_port_nxt;
            rsp_data     <= rsp_data_nxt;
            rsp_valid    <= rsp_valid_nxt;
            write_strobe <= write_strobe_nxt;
            read_strobe  <= read_strobe_nxt;
        end
    end

    // A set in the same cycle as irq_clear takes priority.
    assign irq_set = (IRQ_EDGE != 0) ? (interrupt & ~irq_hist) : interrupt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_hist    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_hist <= interrupt;
            if (irq_set) begin
                irq_pending <= 1'b1;
            end else if (irq_clear) begin
                irq_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pb_port_master.sv
// Directed bench for pb_port_master: table of single transactions plus hand-written
// back-to-back, reset-abort and interrupt sequences.
module tb_pb_port_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_port;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       interrupt;
    logic       irq_pending;
    logic       irq_clear;

    logic       lvl_cmd_ready;
    logic       lvl_rsp_valid;
    logic [7:0] lvl_rsp_data;
    logic [7:0] lvl_port_id;
    logic [7:0] lvl_out_port;
    logic       lvl_write_strobe;
    logic       lvl_read_strobe;
    logic       lvl_irq_pending;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_rsp;

    always #5 clk = ~clk;

    pb_port_master #(.IRQ_EDGE(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_port(cmd_port), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .port_id(port_id), .out_port(out_port), .in_port(in_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .interrupt(interrupt), .irq_pending(irq_pending), .irq_clear(irq_clear)
    );

    pb_port_master #(.IRQ_EDGE(0)) dut_lvl (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(lvl_cmd_ready), .cmd_write(cmd_write),
        .cmd_port(cmd_port), .cmd_data(cmd_data),
        .rsp_valid(lvl_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(lvl_rsp_data),
        .port_id(lvl_port_id), .out_port(lvl_out_port), .in_port(in_port),
        .write_strobe(lvl_write_strobe), .read_strobe(lvl_read_strobe),
        .interrupt(interrupt), .irq_pending(lvl_irq_pending), .irq_clear(irq_clear)
    );

    typedef struct {
        logic       wr;
        logic [7:0] port;
        logic [7:0] data;
        logic [7:0] inp;
        logic [7:0] exp_rsp;
        int         hold;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_txn(input vec_t v);
        chk("idle_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_port  = v.port;
        cmd_data  = v.data;
        in_port   = v.inp;
        tick();
        cmd_valid = 1'b0;
        cmd_port  = 8'hEE;
        cmd_data  = 8'hEE;
        chk("setup_port_id", port_id, v.port);
        chk("setup_out_port", out_port, v.data);
        chk("setup_strobes", {write_strobe, read_strobe}, 2'b00);
        chk("setup_ready", cmd_ready, 0);
        tick();
        chk("strobe_port_id", port_id, v.port);
        chk("strobe_out_port", out_port, v.data);
        chk("strobe_strobes", {write_strobe, read_strobe}, {v.wr, ~v.wr});
        chk("lvl_strobe", {lvl_port_id, lvl_out_port, lvl_write_strobe, lvl_read_strobe},
            {v.port, v.data, v.wr, ~v.wr});
        tick();
        in_port = ~v.inp;
        if (v.wr) begin
            chk("wr_ready_after_3", cmd_ready, 1);
            chk("wr_strobes_low", {write_strobe, read_strobe}, 2'b00);
            chk("wr_no_rsp", rsp_valid, 0);
            chk("wr_rsp_data_held", rsp_data, last_rsp);
        end else begin
            last_rsp = v.exp_rsp;
            // A competing command is offered while the response waits.
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_port  = 8'h77;
            for (int i = 0; i < v.hold; i++) begin
                chk("resp_hold_valid", rsp_valid, 1);
                chk("resp_hold_data", rsp_data, v.exp_rsp);
                chk("resp_hold_ready", cmd_ready, 0);
                chk("resp_hold_port", port_id, v.port);
                tick();
            end
            cmd_valid = 1'b0;
            chk("resp_valid", rsp_valid, 1);
            chk("resp_data", rsp_data, v.exp_rsp);
            chk("resp_strobes", {write_strobe, read_strobe}, 2'b00);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            chk("resp_done_valid", rsp_valid, 0);
            chk("resp_done_ready", cmd_ready, 1);
            chk("resp_done_data", rsp_data, v.exp_rsp);
        end
        chk("lvl_tail", {lvl_cmd_ready, lvl_rsp_valid, lvl_rsp_data}, {1'b1, 1'b0, last_rsp});
    endtask

    initial begin
        vecs[0] = '{wr: 1'b1, port: 8'h01, data: 8'h5A, inp: 8'h00, exp_rsp: 8'h00, hold: 0};
        vecs[1] = '{wr: 1'b0, port: 8'h00, data: 8'h00, inp: 8'hA5, exp_rsp: 8'hA5, hold: 0};
        vecs[2] = '{wr: 1'b0, port: 8'h7F, data: 8'h12, inp: 8'h3C, exp_rsp: 8'h3C, hold: 5};
        vecs[3] = '{wr: 1'b1, port: 8'hFF, data: 8'h00, inp: 8'h66, exp_rsp: 8'h00, hold: 0};
        vecs[4] = '{wr: 1'b0, port: 8'h80, data: 8'hFF, inp: 8'hFF, exp_rsp: 8'hFF, hold: 2};
        vecs[5] = '{wr: 1'b1, port: 8'h10, data: 8'hC3, inp: 8'h00, exp_rsp: 8'h00, hold: 0};

        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_port  = 8'h33;
        cmd_data  = 8'h44;
        rsp_ready = 1'b0;
        in_port   = 8'h00;
        interrupt = 1'b0;
        irq_clear = 1'b0;
        last_rsp  = 8'h00;
        tick();
        tick();
        chk("rst_ready", cmd_ready, 0);
        chk("rst_outputs", {port_id, out_port, rsp_data, rsp_valid, write_strobe, read_strobe}, 0);
        chk("rst_irq", {irq_pending, lvl_irq_pending}, 2'b00);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Back-to-back writes with cmd_valid held high.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_port  = 8'h02;
        cmd_data  = 8'h11;
        tick();
        cmd_port = 8'h03;
        cmd_data = 8'h22;
        chk("b2b_setup0_ws", write_strobe, 0);
        tick();
        chk("b2b_pulse0", {write_strobe, port_id, out_port}, {1'b1, 8'h02, 8'h11});
        tick();
        chk("b2b_gap1", {write_strobe, cmd_ready}, 2'b01);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_gap2", {write_strobe, port_id}, {1'b0, 8'h03});
        tick();
        chk("b2b_pulse1", {write_strobe, read_strobe, port_id, out_port}, {2'b10, 8'h03, 8'h22});
        tick();
        chk("b2b_end", {write_strobe, cmd_ready}, 2'b01);

        // Reset asserted during the STROBE cycle of a read.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_port  = 8'h44;
        cmd_data  = 8'h55;
        in_port   = 8'h99;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("abort_strobe", read_strobe, 1);
        reset = 1'b0;
        tick();
        chk("abort_outputs", {port_id, out_port, rsp_data, rsp_valid, write_strobe, read_strobe}, 0);
        chk("abort_ready", cmd_ready, 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_rsp", {rsp_valid, read_strobe, cmd_ready}, 3'b001);
        end

        // Interrupt latching: edge mode on dut, level mode on dut_lvl.
        interrupt = 1'b1;
        irq_clear = 1'b1;
        tick();
        chk("irq_set_wins", {irq_pending, lvl_irq_pending}, 2'b11);
        irq_clear = 1'b0;
        tick();
        chk("irq_hold", irq_pending, 1);
        irq_clear = 1'b1;
        tick();
        chk("irq_clear_high", {irq_pending, lvl_irq_pending}, 2'b01);
        irq_clear = 1'b0;
        tick();
        tick();
        chk("irq_no_reset_while_high", irq_pending, 0);
        interrupt = 1'b0;
        tick();
        chk("irq_low", {irq_pending, lvl_irq_pending}, 2'b01);
        irq_clear = 1'b1;
        tick();
        chk("irq_lvl_clear", lvl_irq_pending, 0);
        irq_clear = 1'b0;
        interrupt = 1'b1;
        tick();
        chk("irq_new_edge", {irq_pending, lvl_irq_pending}, 2'b11);
        interrupt = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
